// File: rtl/fp_switch_scan_pkg.sv
// Shared constants for the front-panel switch scanner: display-select codes,
// button/toggle indices and the command lockout state type.
package fp_switch_scan_pkg;

    localparam logic [5:0] DSEL_STATE  = 6'b100000;
    localparam logic [5:0] DSEL_STATUS = 6'b010000;
    localparam logic [5:0] DSEL_AC     = 6'b001000;
    localparam logic [5:0] DSEL_MB     = 6'b000100;
    localparam logic [5:0] DSEL_MQ     = 6'b000010;
    localparam logic [5:0] DSEL_BUS    = 6'b000001;

    localparam int BTN_ADDR_LOAD      = 0;
    localparam int BTN_EXTD_ADDR_LOAD = 1;
    localparam int BTN_CLEAR          = 2;
    localparam int BTN_CONT           = 3;
    localparam int BTN_EXAM           = 4;
    localparam int BTN_DEP            = 5;
    localparam int BTN_SEL_STEP       = 6;

    localparam int TOG_HALT  = 0;
    localparam int TOG_SSTEP = 1;

    typedef enum logic {StIdle, StHeld} lock_state_e;

    // Any non-one-hot value recovers to DSEL_STATE, so dsel can never stick.
    function automatic logic [5:0] dsel_rotate(input logic [5:0] cur);
        logic [5:0] nxt;
        case (cur)
            DSEL_STATE:  nxt = DSEL_STATUS;
            DSEL_STATUS: nxt = DSEL_AC;
            DSEL_AC:     nxt = DSEL_MB;
            DSEL_MB:     nxt = DSEL_MQ;
            DSEL_MQ:     nxt = DSEL_BUS;
            default:     nxt = DSEL_STATE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/fp_debounce.sv
// Two-flop synchroniser followed by a counting debouncer for one panel input.
module fp_debounce #(
    parameter int unsigned DB_CYCLES = 50000,
    parameter int unsigned DB_W      = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam logic [DB_W-1:0] CntMax = DB_W'(DB_CYCLES - 1);

    logic [1:0]      sync_q;
    logic            level_q, level_d;
    logic [DB_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], din};
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    // Only an unbroken run of DB_CYCLES disagreeing samples flips the level.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CntMax) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign dout = level_q;

endmodule

// File: rtl/fp_switch_scan.sv
// PDP-8/e front-panel input scanner: debounced levels, arbitrated one-shot
// command pulses with hold lockout, and the rotating display select.
module fp_switch_scan
    import fp_switch_scan_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 50000,
    parameter int unsigned DB_W      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [0:11] sr_raw,
    input  logic [0:6]  btn_raw,
    input  logic [0:1]  tog_raw,
    output logic [0:11] sr,
    output logic        halt_sw,
    output logic        sstep_sw,
    output logic        addr_load,
    output logic        ext_addr_load,
    output logic        clear,
    output logic        cont,
    output logic        exam,
    output logic        dep,
    output logic        sw_active,
    output logic [5:0]  dsel
);

    logic [0:6]  btn_lvl;
    logic [0:1]  tog_lvl;
    logic [0:6]  btn_prev_q;
    logic [0:6]  press;
    logic [0:5]  pulse_q, pulse_d;
    logic [5:0]  dsel_q, dsel_d;
    lock_state_e state_q, state_d;

    for (genvar i = 0; i < 12; i++) begin : g_sr
        fp_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db (
            .clk(clk), .reset(reset), .din(sr_raw[i]), .dout(sr[i])
        );
    end

    for (genvar i = 0; i < 7; i++) begin : g_btn
        fp_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db (
            .clk(clk), .reset(reset), .din(btn_raw[i]), .dout(btn_lvl[i])
        );
    end

    for (genvar i = 0; i < 2; i++) begin : g_tog
        fp_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db (
            .clk(clk), .reset(reset), .din(tog_raw[i]), .dout(tog_lvl[i])
        );
    end

    assign press = btn_lvl & ~btn_prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_prev_q <= '0;
            pulse_q    <= '0;
            dsel_q     <= DSEL_STATE;
            state_q    <= StIdle;
        end else begin
            btn_prev_q <= btn_lvl;
            pulse_q    <= pulse_d;
            dsel_q     <= dsel_d;
            state_q    <= state_d;
        end
    end

    // Losers of a simultaneous press stay locked out because HELD persists
    // until every command level has dropped.
    always_comb begin
        state_d = state_q;
        pulse_d = '0;
        unique case (state_q)
            StIdle: begin
                if (|press[0:5]) begin
                    state_d = StHeld;
                    if (press[BTN_CLEAR])               pulse_d[BTN_CLEAR]          = 1'b1;
                    else if (press[BTN_ADDR_LOAD])      pulse_d[BTN_ADDR_LOAD]      = 1'b1;
                    else if (press[BTN_EXTD_ADDR_LOAD]) pulse_d[BTN_EXTD_ADDR_LOAD] = 1'b1;
                    else if (press[BTN_EXAM])           pulse_d[BTN_EXAM]           = 1'b1;
                    else if (press[BTN_DEP])            pulse_d[BTN_DEP]            = 1'b1;
                    else                                pulse_d[BTN_CONT]           = 1'b1;
                end
            end
            StHeld: begin
                if (btn_lvl[0:5] == 6'b000000) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        dsel_d = dsel_q;
        if (press[BTN_SEL_STEP]) dsel_d = dsel_rotate(dsel_q);
    end

    assign halt_sw       = tog_lvl[TOG_HALT];
    assign sstep_sw      = tog_lvl[TOG_SSTEP];
    assign addr_load     = pulse_q[BTN_ADDR_LOAD];
    assign ext_addr_load = pulse_q[BTN_EXTD_ADDR_LOAD];
    assign clear         = pulse_q[BTN_CLEAR];
    assign cont          = pulse_q[BTN_CONT];
    assign exam          = pulse_q[BTN_EXAM];
    assign dep           = pulse_q[BTN_DEP];
    assign sw_active     = (state_q == StHeld);
    assign dsel          = dsel_q;

endmodule

// File: doc/fp_switch_scan.md
# fp_switch_scan

Input side of the PDP-8/e front panel. Synchronises and debounces the raw panel switches and buttons, and turns them into clean levels and single-cycle command pulses for the processor state machine. It also generates the one-hot display-select vector that the panel display multiplexer consumes. It sits between the board-level switch pins and the CPU/display logic, running in the system clock domain.

## Interface
Parameters:
- DB_CYCLES, 16'd50000: consecutive stable samples required to accept a new input level (1 ms at 50 MHz).
- DB_W, 16: debounce counter width; DB_CYCLES must fit.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- sr_raw  in  [0:11]  raw switch-register toggles.
- btn_raw  in  [0:6]  raw momentary buttons: 0 ADDR_LOAD, 1 EXTD_ADDR_LOAD, 2 CLEAR, 3 CONT, 4 EXAM, 5 DEP, 6 SEL_STEP.
- tog_raw  in  [0:1]  raw toggles: 0 HALT, 1 SING_STEP.
- sr  out  [0:11]  debounced switch register.
- halt_sw, sstep_sw  out  1 each  debounced toggle levels.
- addr_load, ext_addr_load, clear, cont, exam, dep  out  1 each  single-cycle command pulses.
- sw_active  out  1  high while an accepted command button is still held.
- dsel  out  [5:0]  one-hot display select (bit 5 state, 4 status, 3 ac, 2 mb, 1 mq, 0 io_bus).

## Operation
- Every raw input passes through a 2-flop synchroniser, then its own debouncer.
- Debouncer behaviour:
  - Holds the accepted level and a counter.
  - When the synchronised sample equals the accepted level, the counter clears.
  - Otherwise the counter increments. When the counter reaches DB_CYCLES−1, the accepted level flips and the counter clears.
  - A glitch shorter than DB_CYCLES samples is never accepted.
- sr, halt_sw, sstep_sw are the accepted levels, registered.
- Command buttons (indices 0–5), per button:
  - A rising edge of the accepted level is a press.
  - Each press produces at most one output pulse, lasting exactly one clk.
- Arbitration:
  - If presses occur in the same cycle, only the highest-priority one pulses: CLEAR > ADDR_LOAD > EXTD_ADDR_LOAD > EXAM > DEP > CONT.
  - The losing buttons are latched out until their own release.
- Lockout FSM:
  - States: IDLE and HELD.
  - IDLE → HELD on any accepted command press; the winning pulse is emitted on this transition.
  - HELD → IDLE when all six accepted command levels are 0.
  - In HELD, new presses produce no pulse, and a still-held button does not pulse after return to IDLE.
  - sw_active = (state == HELD).
- SEL_STEP: each accepted press rotates dsel right: 100000→010000→…→000001→100000. SEL_STEP is independent of the lockout FSM.
- dsel is always exactly one-hot.

## Timing
- Reset values:
  - sr = 0, halt_sw = 0, sstep_sw = 0.
  - All pulses = 0, sw_active = 0, dsel = 6'b100000.
  - Debouncers are at level 0 with count 0; FSM is IDLE.
- Latency from a raw edge that stays stable to the accepted level change: 2 sync cycles + DB_CYCLES cycles.
- Command pulses and the dsel update occur in the cycle after the accepted level rises. sw_active rises in the same cycle as the pulse.
- sw_active falls one cycle after the last command button's accepted level falls.
- Reset asserted mid-debounce or while HELD: everything returns to reset values immediately. A button still held after reset is accepted as a press after the debounce latency (accepted level restarts at 0).
- The counter saturates logically at DB_CYCLES−1; it never wraps.

## Structure
- Sub-module fp_debounce:
  - Parameters DB_CYCLES, DB_W.
  - Ports clk, reset, din, dout.
  - Includes the synchroniser.
  - Instantiated 21 times (12 + 7 + 2) via generate.
- Add to parameters.v:
  - DSEL_STATE…DSEL_BUS one-hot constants.
  - Button index constants BTN_ADDR_LOAD…BTN_SEL_STEP.
  - Toggle index constants TOG_HALT, TOG_SSTEP.

## Test plan
All scenarios use DB_CYCLES = 4.
- Reset → all outputs at reset values, dsel = 100000. Then sr_raw = 12'o5252 held for 6 cycles → sr = 12'o5252; sr holds 0 before cycle 6.
- EXAM bounced 1,0,1,0 on alternate cycles, then held 10 cycles → exactly one exam pulse. sw_active high from the pulse until 1 cycle after the debounced release.
- CLEAR and DEP asserted in the same cycle and held → clear pulses once, dep never pulses. Release CLEAR only → still no dep pulse. Release DEP → sw_active = 0.
- Hold ADDR_LOAD; press CONT while it is held → no cont pulse. Release both, press CONT again → one cont pulse.
- SEL_STEP pressed 7 times with full debounce each → dsel steps 010000, 001000, 000100, 000010, 000001, 100000, 010000.
- Hold DEP past its pulse, assert reset for 1 cycle → sw_active = 0, dsel = 100000. With DEP still held, exactly one new dep pulse after 6 cycles.
